// File: rtl/exec_multicycle.sv
// rtl/exec_multicycle.sv - multi-cycle execute unit: single-cycle ALU ops plus a 64-step shift-add multiplier
//
// Purpose:
//   Accepts one operation per request from IDLE. Plain ALU operations finish
//   in a single cycle. MUL runs an unsigned shift-add over 64 cycles, handling
//   one multiplier bit per cycle, LSB first. The result is presented for
//   exactly one cycle with RegWrite asserted, so it can drive the
//   register-file write port directly.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous active-high reset
//   start      in   1   operation request, sampled only in IDLE
//   ALUOp      in   3   operation select, latched when a request is accepted
//   ReadData1  in  64   operand A
//   ReadData2  in  64   operand B
//   RD_in      in   5   destination index, latched when a request is accepted
//   busy       out  1   high whenever the unit is not in IDLE
//   done       out  1   one-cycle result-valid pulse
//   WriteData  out 64   result, held until the next done or reset
//   RD         out  5   destination index, held until the next done or reset
//   RegWrite   out  1   register-file write enable, identical to done

module exec_multicycle (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  ALUOp,
  input  logic [63:0] ReadData1,
  input  logic [63:0] ReadData2,
  input  logic [4:0]  RD_in,
  output logic        busy,
  output logic        done,
  output logic [63:0] WriteData,
  output logic [4:0]  RD,
  output logic        RegWrite
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [5:0]  cnt;        // index of the multiplier bit handled at the next edge
  logic [63:0] acc;        // running partial product
  logic [63:0] mcand;      // A << cnt, kept pre-shifted so no barrel shifter is needed
  logic [63:0] mplier;     // B >> cnt, so the bit of interest is always mplier[0]
  logic [4:0]  rd_hold;    // destination of the in-flight multiply

  logic [63:0] alu_result;
  logic [63:0] acc_next;

  // Single-cycle operations. MUL and the reserved code both yield 0 here;
  // MUL never takes this path because it is routed to the multiplier.
  always_comb begin
    alu_result = 64'd0;
    unique case (ALUOp)
      OP_ADD:  alu_result = ReadData1 + ReadData2;
      OP_SUB:  alu_result = ReadData1 - ReadData2;
      OP_AND:  alu_result = ReadData1 & ReadData2;
      OP_OR:   alu_result = ReadData1 | ReadData2;
      OP_XOR:  alu_result = ReadData1 ^ ReadData2;
      OP_SLL:  alu_result = ReadData1 << ReadData2[5:0];
      default: alu_result = 64'd0;
    endcase
  end

  // One shift-add step: add A<<i when multiplier bit i is set. Bits that
  // move past bit 63 of mcand are dropped, which gives the modulo-2^64 product.
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : 64'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 6'd0;
      acc       <= 64'd0;
      mcand     <= 64'd0;
      mplier    <= 64'd0;
      rd_hold   <= 5'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      RegWrite  <= 1'b0;
      WriteData <= 64'd0;
      RD        <= 5'd0;
    end else begin
      unique case (state)
        IDLE: begin
          done     <= 1'b0;
          RegWrite <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (ALUOp == OP_MUL) begin
              state   <= MUL;
              mcand   <= ReadData1;
              mplier  <= ReadData2;
              rd_hold <= RD_in;
              acc     <= 64'd0;
              cnt     <= 6'd0;
            end else begin
              state     <= DONE;
              WriteData <= alu_result;
              RD        <= RD_in;
              done      <= 1'b1;
              RegWrite  <= 1'b1;
            end
          end
        end

        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          // cnt only advances here, so its natural 63->0 rollover coincides
          // with the final step and the move to DONE.
          cnt    <= cnt + 6'd1;
          if (cnt == 6'd63) begin
            state     <= DONE;
            WriteData <= acc_next;
            RD        <= rd_hold;
            done      <= 1'b1;
            RegWrite  <= 1'b1;
          end
        end

        DONE: begin
          // A start seen here is dropped, not queued.
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          RegWrite <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          RegWrite <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_multicycle.sv
// tb/tb_exec_multicycle.sv - self-checking bench for exec_multicycle

module tb_exec_multicycle;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  ALUOp;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;
  logic [4:0]  RD_in;
  logic        busy;
  logic        done;
  logic [63:0] WriteData;
  logic [4:0]  RD;
  logic        RegWrite;

  int tests = 0;
  int fails = 0;

  exec_multicycle dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ALUOp     (ALUOp),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .RD_in     (RD_in),
    .busy      (busy),
    .done      (done),
    .WriteData (WriteData),
    .RD        (RD),
    .RegWrite  (RegWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the unit idle again.
  task automatic run_alu(input vec_t v);
    start = 1'b1; ALUOp = v.op; ReadData1 = v.a; ReadData2 = v.b; RD_in = v.rd;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ReadData1 = ~v.a; ReadData2 = ~v.b; RD_in = ~v.rd; ALUOp = ~v.op;
    chk("alu_done", {63'd0, done}, 64'd1);
    chk("alu_regwrite", {63'd0, RegWrite}, 64'd1);
    chk("alu_busy", {63'd0, busy}, 64'd1);
    chk("alu_writedata", WriteData, v.exp);
    chk("alu_rd", {59'd0, RD}, {59'd0, v.rd});
    @(posedge clk);
    @(negedge clk);
    chk("alu_done_clear", {63'd0, done}, 64'd0);
    chk("alu_busy_clear", {63'd0, busy}, 64'd0);
    chk("alu_wd_hold", WriteData, v.exp);
  endtask

  task automatic run_mul(input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                         input logic [63:0] exp, input bit inject);
    int busy_n;
    int done_n;
    int done_at;
    busy_n = 0; done_n = 0; done_at = -1;
    start = 1'b1; ALUOp = 3'b110; ReadData1 = a; ReadData2 = b; RD_in = rd;
    @(posedge clk);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = 1'b0; ReadData1 = 64'd0; ReadData2 = 64'd0; RD_in = 5'd0;
      end
      if (inject && i == 10) begin
        start = 1'b1; ALUOp = 3'b000; ReadData1 = 64'd1; ReadData2 = 64'd1; RD_in = 5'd7;
      end
      if (i == 11) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = i;
        chk("mul_result", WriteData, exp);
        chk("mul_rd", {59'd0, RD}, {59'd0, rd});
        chk("mul_regwrite", {63'd0, RegWrite}, 64'd1);
      end
    end
    chk("mul_busy_cycles", 64'(busy_n), 64'd65);
    chk("mul_done_count", 64'(done_n), 64'd1);
    chk("mul_done_latency", 64'(done_at), 64'd64);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{3'b000, 64'd5, 64'd7, 5'd3, 64'd12};
    vecs[1] = '{3'b001, 64'd0, 64'd1, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2] = '{3'b010, 64'hFF00_FF00_0000_FFFF, 64'h0F0F_0F0F_1234_5678, 5'd5, 64'h0F00_0F00_0000_5678};
    vecs[3] = '{3'b011, 64'hF000_0000_0000_0001, 64'h0000_0000_0000_0010, 5'd6, 64'hF000_0000_0000_0011};
    vecs[4] = '{3'b100, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_0000_0000, 5'd7, 64'h5555_5555_AAAA_AAAA};
    vecs[5] = '{3'b101, 64'd1, 64'd67, 5'd8, 64'd8};
    vecs[6] = '{3'b101, 64'h8000_0000_0000_0001, 64'd1, 5'd31, 64'd2};
    vecs[7] = '{3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd9, 64'd0};
    vecs[8] = '{3'b111, 64'd5, 64'd7, 5'd0, 64'd0};
    vecs[9] = '{3'b101, 64'd3, 64'd63, 5'd10, 64'h8000_0000_0000_0000};

    reset = 1'b1; start = 1'b1; ALUOp = 3'b000; ReadData1 = 64'd1; ReadData2 = 64'd1; RD_in = 5'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_regwrite", {63'd0, RegWrite}, 64'd0);
    chk("reset_writedata", WriteData, 64'd0);
    chk("reset_rd", {59'd0, RD}, 64'd0);
    reset = 1'b0; start = 1'b0;
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_alu(vecs[i]);

    run_mul(64'd6, 64'd7, 5'd12, 64'd42, 1'b1);
    run_mul(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 5'd13, 64'd0, 1'b0);
    run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd14, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);

    // Back-to-back: start held high is accepted every second cycle.
    start = 1'b1; ALUOp = 3'b000; ReadData1 = 64'd1; ReadData2 = 64'd2; RD_in = 5'd1;
    @(posedge clk); @(negedge clk);
    chk("b2b_done_first", {63'd0, done}, 64'd1);
    @(posedge clk); @(negedge clk);
    chk("b2b_ignored_in_done", {63'd0, done}, 64'd0);
    chk("b2b_idle_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); @(negedge clk);
    chk("b2b_done_second", {63'd0, done}, 64'd1);
    start = 1'b0; RD_in = 5'd22; ReadData1 = 64'd100;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("hold_rd", {59'd0, RD}, 64'd1);
    chk("hold_writedata", WriteData, 64'd3);
    chk("hold_no_done", {63'd0, done}, 64'd0);

    // Reset in the middle of a multiply aborts it without a write.
    begin
      int done_seen;
      done_seen = 0;
      start = 1'b1; ALUOp = 3'b110; ReadData1 = 64'd6; ReadData2 = 64'd7; RD_in = 5'd15;
      @(posedge clk);
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (i == 0) start = 1'b0;
        if (done || RegWrite) done_seen++;
      end
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("abort_no_done", 64'(done_seen), 64'd0);
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_done", {63'd0, done}, 64'd0);
      chk("abort_regwrite", {63'd0, RegWrite}, 64'd0);
      chk("abort_writedata", WriteData, 64'd0);
      chk("abort_rd", {59'd0, RD}, 64'd0);
      reset = 1'b0;
      start = 1'b1; ALUOp = 3'b000; ReadData1 = 64'd1; ReadData2 = 64'd1; RD_in = 5'd9;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      chk("post_reset_done", {63'd0, done}, 64'd1);
      chk("post_reset_writedata", WriteData, 64'd2);
      chk("post_reset_rd", {59'd0, RD}, 64'd9);
      @(posedge clk); @(negedge clk);
      chk("post_reset_idle", {63'd0, busy}, 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
